column_sched_ctrl: RTL

COLUMN_SCHED_CTRL -- requirements
Module: column_sched_ctrl

---
 rtl/column_ctrl_pkg.sv | 22 ++
 rtl/col_addr_gen.sv | 21 ++
 rtl/column_sched_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/column_ctrl_pkg.sv
// Shared types and constants for the column scheduler: FSM states, reducer
// opcodes and default datapath widths.
package column_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int RES_W  = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_OP,
        CAP_OP,
        RD_NUM,
        CAP_NUM,
        DONE,
        WAIT,
        FIN
    } state_t;

endpackage

// File: rtl/col_addr_gen.sv
// Operand-buffer address for a column: operator row (at index rows) or data row,
// laid out with a row stride of COLS_MAX. Purely combinational.
module col_addr_gen
    import column_ctrl_pkg::*;
#(
    parameter int COLS_MAX = 16,
    parameter int ADDR_W   = 8
) (
    input  logic              op_sel,
    input  logic [3:0]        row,
    input  logic [3:0]        rows,
    input  logic [4:0]        col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_sel;

    assign row_sel = ADDR_W'(op_sel ? rows : row);
    assign addr    = row_sel * ADDR_W'(COLS_MAX) + ADDR_W'(col);

endmodule

// File: rtl/column_sched_ctrl.sv
// Column scheduler: per column reads the operator row then each data row, feeds
// the reducer, and accumulates column results. Optional SCHED_OVF_DETECT_EN adds ovf.
module column_sched_ctrl
    import column_ctrl_pkg::*;
#(
    parameter int COLS_MAX = 16,
    parameter int ROWS_MAX = 8,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        rows,
    input  logic [4:0]        cols,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              red_num_valid,
    output logic [DATA_W-1:0] red_num,
    output logic              red_op_valid,
    output logic              red_op,
    output logic              red_done,
    input  logic              red_result_valid,
    input  logic [RES_W-1:0]  red_result,
    output logic              grand_valid,
    output logic [RES_W-1:0]  grand_total,
    output logic [4:0]        col_idx
`ifdef SCHED_OVF_DETECT_EN
   ,output logic              ovf
`endif
);

    localparam logic [3:0] ROWS_L = 4'(ROWS_MAX);
    localparam logic [4:0] COLS_L = 5'(COLS_MAX);

    state_t            state, state_nxt;
    logic [3:0]        rows_q, rows_nxt, r_q, r_nxt, rows_cl;
    logic [4:0]        cols_q, cols_nxt, col_nxt, cols_cl;
    logic              zero_q, zero_nxt;
    logic [RES_W-1:0]  total_nxt;
    logic [RES_W:0]    sum;
    logic              rd_nxt, opv_nxt, op_nxt, nv_nxt, done_nxt, gv_nxt;
    logic [DATA_W-1:0] num_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              accept;

    assign rows_cl = (rows > ROWS_L) ? ROWS_L : rows;
    assign cols_cl = (cols > COLS_L) ? COLS_L : cols;
    assign accept  = (state == IDLE) && start;
    assign sum     = {1'b0, grand_total} + {1'b0, red_result};
    assign busy    = (state != IDLE);

    // Address is generated from next-cycle indices so it registers alongside mem_rd.
    col_addr_gen #(.COLS_MAX(COLS_MAX), .ADDR_W(ADDR_W)) u_addr (
        .op_sel (state_nxt == RD_OP),
        .row    (r_nxt),
        .rows   (rows_nxt),
        .col    (col_nxt),
        .addr   (addr_nxt)
    );

    always_comb begin
        state_nxt = state;
        rows_nxt  = rows_q;
        cols_nxt  = cols_q;
        r_nxt     = r_q;
        col_nxt   = col_idx;
        zero_nxt  = zero_q;
        total_nxt = grand_total;
        rd_nxt    = 1'b0;
        opv_nxt   = 1'b0;
        op_nxt    = red_op;
        nv_nxt    = 1'b0;
        num_nxt   = red_num;
        done_nxt  = 1'b0;
        gv_nxt    = 1'b0;
        case (state)
            IDLE: if (start) begin
                rows_nxt  = rows_cl;
                cols_nxt  = cols_cl;
                total_nxt = '0;
                col_nxt   = '0;
                if (rows_cl == 4'd0 || cols_cl == 5'd0) begin
                    zero_nxt  = 1'b1;
                    state_nxt = FIN;
                end else begin
                    zero_nxt  = 1'b0;
                    rd_nxt    = 1'b1;
                    state_nxt = RD_OP;
                end
            end
            RD_OP:  state_nxt = CAP_OP;
            CAP_OP: begin
                opv_nxt   = 1'b1;
                op_nxt    = mem_rdata[0];
                r_nxt     = '0;
                rd_nxt    = 1'b1;
                state_nxt = RD_NUM;
            end
            RD_NUM: state_nxt = CAP_NUM;
            CAP_NUM: begin
                nv_nxt  = 1'b1;
                num_nxt = mem_rdata;
                r_nxt   = r_q + 4'd1;
                if ({1'b0, r_q} + 5'd1 < {1'b0, rows_q}) begin
                    rd_nxt    = 1'b1;
                    state_nxt = RD_NUM;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = WAIT;
            WAIT: if (red_result_valid) begin
                total_nxt = sum[RES_W-1:0];
                col_nxt   = col_idx + 5'd1;
                if (col_idx == cols_q - 5'd1) begin
                    gv_nxt    = 1'b1;
                    state_nxt = FIN;
                end else begin
                    rd_nxt    = 1'b1;
                    state_nxt = RD_OP;
                end
            end
            // A degenerate job has no WAIT, so its completion pulse is issued here.
            FIN: begin
                gv_nxt    = zero_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            r_q           <= '0;
            col_idx       <= '0;
            zero_q        <= 1'b0;
            grand_total   <= '0;
            mem_rd        <= 1'b0;
            mem_addr      <= '0;
            red_op_valid  <= 1'b0;
            red_op        <= OP_ADD;
            red_num_valid <= 1'b0;
            red_num       <= '0;
            red_done      <= 1'b0;
            grand_valid   <= 1'b0;
        end else begin
            state         <= state_nxt;
            rows_q        <= rows_nxt;
            cols_q        <= cols_nxt;
            r_q           <= r_nxt;
            col_idx       <= col_nxt;
            zero_q        <= zero_nxt;
            grand_total   <= total_nxt;
            mem_rd        <= rd_nxt;
            if (rd_nxt)
                mem_addr  <= addr_nxt;
            red_op_valid  <= opv_nxt;
            red_op        <= op_nxt;
            red_num_valid <= nv_nxt;
            red_num       <= num_nxt;
            red_done      <= done_nxt;
            grand_valid   <= gv_nxt;
        end
    end

`ifdef SCHED_OVF_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (accept)
            ovf <= 1'b0;
        else if (state == WAIT && red_result_valid && sum[RES_W])
            ovf <= 1'b1;
    end
`else
    logic unused_carry;
    assign unused_carry = sum[RES_W] | accept;
`endif

endmodule
